// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst tenure: an owner keeps the grant while it
// keeps requesting, up to MAX_HOLD cycles, after which the grant rotates.
module rr_burst_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in,
  output logic [N-1:0]   out,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempted
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   out_d;
  logic           valid_d;
  logic [IDW-1:0] owner_d;
  logic           pre_d;

  logic [IDW-1:0] owner_inc;
  logic [IDW-1:0] search_start;
  logic [IDW-1:0] winner;
  logic           found;

  // Index following the current owner, wrapping at N-1.
  assign owner_inc = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);

  // Wrap-around search for the first request at or after search_start.
  always_comb begin
    search_start = (state_q == IDLE) ? ptr_q : owner_inc;
    found        = 1'b0;
    winner       = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && in[IDW'((int'(search_start) + k) % N)]) begin
        found  = 1'b1;
        winner = IDW'((int'(search_start) + k) % N);
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    out_d   = out;
    valid_d = grant_valid;
    owner_d = grant_id;
    pre_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          owner_d = winner;
          hold_d  = '0;
          out_d   = N'(1) << winner;
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (in[grant_id] && (hold_q < HW'(MAX_HOLD - 1))) begin
          hold_d = hold_q + HW'(1);
        end else begin
          // Tenure ends by release or by hitting the hold limit.
          ptr_d  = owner_inc;
          hold_d = '0;
          if (found) begin
            owner_d = winner;
            out_d   = N'(1) << winner;
            valid_d = 1'b1;
            pre_d   = in[grant_id];
          end else begin
            state_d = IDLE;
            out_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      out         <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      preempted   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      out         <= out_d;
      grant_valid <= valid_d;
      grant_id    <= owner_d;
      preempted   <= pre_d;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out));
  a_valid:  assert property (@(posedge clk) disable iff (rst) grant_valid == (|out));
  a_hold:   assert property (@(posedge clk) disable iff (rst) hold_q < HW'(MAX_HOLD));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (N=4, MAX_HOLD=4).
module tb_rr_burst_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IDW      = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in;
  logic [N-1:0]   out;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempted;

  int checks = 0;
  int errors = 0;

  rr_burst_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .out         (out),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempted   (preempted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply a request vector for one edge, then settle past the edge.
  task automatic cyc(input logic [N-1:0] req);
    in = req;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(4'b0000);
    cyc(4'b0000);
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_out, input logic e_valid,
                           input logic [1:0] e_id, input logic e_pre);
    check({tag, ".out"},   32'(out),         32'(e_out));
    check({tag, ".valid"}, 32'(grant_valid), 32'(e_valid));
    check({tag, ".id"},    32'(grant_id),    32'(e_id));
    check({tag, ".pre"},   32'(preempted),   32'(e_pre));
  endtask

  initial begin
    rst = 1'b0;
    in  = '0;

    // Reset state and first grant from IDLE.
    do_reset();
    check_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc(4'b0101);
    check_all("first", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Release with handoff, then release to idle, then wrap search from ptr=3.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      cyc(4'b0001);
      check_all("hold0", 4'b0001, 1'b1, 2'd0, 1'b0);
    end
    cyc(4'b0100);
    check_all("handoff", 4'b0100, 1'b1, 2'd2, 1'b0);
    cyc(4'b0000);
    check_all("to_idle", 4'b0000, 1'b0, 2'd2, 1'b0);
    cyc(4'b0011);
    check_all("wrap", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Full contention rotation with preemption pulses.
    do_reset();
    for (int j = 0; j < 17; j++) begin
      logic [1:0] own;
      logic [3:0] oh;
      own = 2'((j / 4) % 4);
      oh  = 4'b0001 << own;
      cyc(4'b1111);
      check_all("rotate", oh, 1'b1, own, (j % 4 == 0) && (j > 0));
    end

    // Single requester regranted at the limit.
    do_reset();
    for (int j = 0; j < 12; j++) begin
      cyc(4'b0010);
      check_all("single", 4'b0010, 1'b1, 2'd1, (j % 4 == 0) && (j > 0));
    end

    // Reset in the middle of owner 1's tenure.
    do_reset();
    for (int j = 0; j < 7; j++) cyc(4'b1111);
    check_all("mid_pre", 4'b0010, 1'b1, 2'd1, 1'b0);
    rst = 1'b1;
    cyc(4'b1111);
    check_all("mid_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    cyc(4'b1111);
    check_all("mid_after", 4'b0001, 1'b1, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
